alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALU selection code produced by the ALU control logic; it is the receiving end of that selection interface.
- Operands and code arrive over a valid/ready handshake. Logic/arithmetic/compare ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle, to save area on the multi-cycle datapath variant.
- The registered result leaves over a second valid/ready handshake toward writeback.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8. SHW = log2(WIDTH) is derived (shift-amount width).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- sel  input  4  ALU selection code
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts only b[SHW-1:0] is used
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered, 1 when result == 0
- illegal  output  1  registered, 1 when the accepted sel is unsupported

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE; result 0; zero 0; illegal 0; out_valid 0; shift counter 0. in_ready is forced 0 while rst is low.
- sel decode:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR.
  - 0100 SLL; 0101 SRL; 0111 SRA.
  - 1000 SLT (signed, result 1/0); 1001 SLTU (unsigned, result 1/0).
  - Any other code: result 0, illegal = 1, zero = 1, 1-cycle path.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry/overflow outputs. SRA fills with a[WIDTH-1]. SRL and SLL fill with 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. Accept occurs on an edge with in_valid = 1; sel, a and b are sampled at that edge.
    - Non-shift op: result, zero and illegal are loaded at the accept edge; next state DONE. out_valid is high in the cycle immediately after the accept edge.
    - Shift op with shamt = b[SHW-1:0] = 0: result = a; next state DONE (same 1-cycle latency).
    - Shift op with shamt = n > 0: load working register with a and counter with n; next state SHIFT.
  - SHIFT: in_ready = 0. Each edge shifts the working register by 1 bit and decrements the counter. On the edge where the counter goes 1 -> 0: load result and zero, go to DONE.
    - out_valid first appears after exactly n SHIFT edges following the accept edge.
    - Intermediate values never appear on result; result keeps its previous value until the load.
  - DONE: out_valid = 1, in_ready = 0. result, zero and illegal are held stable.
    - An edge with out_ready = 1 completes the transfer: out_valid -> 0, state -> IDLE.
    - No new request is accepted in the same edge; minimum issue interval is 2 cycles.
- Inputs (in_valid, sel, a, b) are ignored outside IDLE. in_valid may be held high across an op without causing a duplicate accept.
- out_ready is ignored outside DONE.
- Reset mid-operation (any state): all registers clear immediately, asynchronously. The in-flight op is discarded with no partial result and no spurious out_valid.
- Maximum latency: WIDTH-1 SHIFT cycles, plus the DONE stall caused by backpressure.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, zero 0, out_valid high in the cycle after the accept edge. Same with out_ready = 1 -> back in IDLE next cycle with in_ready = 1.
- Basic logic/SUB ops:
  - SUB a=5 b=5 -> result 0, zero 1.
  - AND 0x0000F0F0 & 0x00000FF0 -> 0x000000F0.
  - OR of the same operands -> 0x0000FFF0.
  - SUB 0 - 1 -> 0xFFFFFFFF.
- Shifts:
  - SRA a=0x80000000 b=31 -> 0xFFFFFFFF; out_valid exactly 31 edges after accept; in_ready 0 throughout.
  - SRL with the same operands -> 0x00000001.
  - SLL a=0x1 b=0x25 -> only shamt 5 is used -> 0x20.
  - SLL shamt 0 -> a after 1 cycle.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE and pulse in_valid with a new op -> result stable, no accept. The new op is accepted only after out_ready = 1 returns the unit to IDLE.
- Reset mid-op: assert rst low during SHIFT (SLL shamt 20, cycle 7) -> out_valid 0, result 0, in_ready 0 immediately. After release, SUB 9-4 -> 5 with normal latency.
- Compare/illegal:
  - SLT a=0xFFFFFFFF b=1 -> 1.
  - SLTU with the same operands -> 0.
  - sel 1111 -> result 0, illegal 1, zero 1; the following legal op clears illegal to 0.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative 1-bit-per-cycle shifts,
// valid/ready handshake on both the request and the registered result.
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SLL  = 4'b0100;
  localparam logic [3:0] SEL_SRL  = 4'b0101;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_SLT  = 4'b1000;
  localparam logic [3:0] SEL_SLTU = 4'b1001;

  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       shk_q, shk_d;

  // Request decode
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic [1:0]       req_shk;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    req_shk  = SH_LL;
    unique case (sel)
      SEL_AND:  alu_res = a & b;
      SEL_OR:   alu_res = a | b;
      SEL_ADD:  alu_res = a + b;
      SEL_SUB:  alu_res = a - b;
      SEL_XOR:  alu_res = a ^ b;
      SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      SEL_SLL: begin is_shift = 1'b1; req_shk = SH_LL; end
      SEL_SRL: begin is_shift = 1'b1; req_shk = SH_RL; end
      SEL_SRA: begin is_shift = 1'b1; req_shk = SH_RA; end
      default:  alu_ill = 1'b1;
    endcase
  end

  // One bit position of the working shift register
  logic [WIDTH-1:0] step;

  always_comb begin
    unique case (shk_q)
      SH_RL:   step = {1'b0, work_q[WIDTH-1:1]};
      SH_RA:   step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step = {work_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    shk_d     = shk_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_shift) begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end else if (shamt == '0) begin
            result_d  = a;
            zero_d    = (a == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end else begin
            work_d  = a;
            cnt_d   = shamt;
            shk_d   = req_shk;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - CNT_ONE;
        // result stays untouched until the final step lands
        if (cnt_q == CNT_ONE) begin
          result_d  = step;
          zero_d    = (step == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      shk_q     <= SH_LL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      shk_q     <= shk_d;
    end
  end

  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: vector table through a scoreboard, plus backpressure and reset-mid-op sequences.
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sel = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  logic [33:0] sb[$];
  vec_t vecs[16];

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: compare on every output handshake
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", result);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("sb_result", result, e[33:2]);
        chk("sb_zero", {31'd0, zero}, {31'd0, e[1]});
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e[0]});
      end
    end
  end

  // Drive a request at #1 after an edge; returns #1 after the accept edge
  task automatic issue(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; sel = s; a = x; b = y;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int edges;
    edges = 0;
    while (!out_valid && edges < 100) begin
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, exp_lat);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input vec_t v);
    issue(v.sel, v.a, v.b);
    sb.push_back({v.res, v.z, v.ill});
    wait_out(v.lat);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 0};
    vecs[2]  = '{4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'b0001, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 0};
    vecs[5]  = '{4'b0111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 31};
    vecs[6]  = '{4'b0101, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 31};
    vecs[7]  = '{4'b0100, 32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 5};
    vecs[8]  = '{4'b0100, 32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1'b0, 0};
    vecs[9]  = '{4'b1000, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0, 0};
    vecs[10] = '{4'b1001, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 0};
    vecs[11] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[12] = '{4'b0011, 32'h0000FF00, 32'h00000FF0, 32'h0000F0F0, 1'b0, 1'b0, 0};
    vecs[13] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[14] = '{4'b0111, 32'h40000000, 32'd4,        32'h04000000, 1'b0, 1'b0, 4};
    vecs[15] = '{4'b0101, 32'h00000010, 32'd5,        32'h00000000, 1'b1, 1'b0, 5};

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // Backpressure: result held, new request ignored while DONE
    issue(4'b0010, 32'd3, 32'd4);
    sb.push_back({32'd7, 1'b0, 1'b0});
    wait_out(0);
    in_valid = 1'b1; sel = 4'b0110; a = 32'd100; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    drain();
    run('{4'b0110, 32'd100, 32'd1, 32'd99, 1'b0, 1'b0, 0});

    // Reset during SHIFT discards the op
    issue(4'b0100, 32'h00000001, 32'd20);
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_shift_no_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    run('{4'b0110, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 0});

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
